// File: rtl/disp_pkg.sv
// disp_pkg: shared resolution codes, frame sizes, FSM states and AXI read
// attributes for the display VRAM read path.
package disp_pkg;
    localparam logic [1:0] P_RESOL_VGA  = 2'b00;
    localparam logic [1:0] P_RESOL_XGA  = 2'b01;
    localparam logic [1:0] P_RESOL_SXGA = 2'b10;
    // Bursts per frame: pixels / 2 pixels per word / 16 words per burst.
    localparam int P_BURSTS_VGA  = 9600;
    localparam int P_BURSTS_XGA  = 24576;
    localparam int P_BURSTS_SXGA = 40960;
    localparam logic [2:0] P_ARSIZE       = 3'b011;
    localparam logic [1:0] P_ARBURST_INCR = 2'b01;
    typedef enum logic [1:0] {S_IDLE, S_WAITVS, S_ISSUE, S_DRAIN} state_t;
endpackage

// File: rtl/disp_inflight_cnt.sv
// disp_inflight_cnt: beats requested but not yet received, plus the FIFO
// space reservation check used to gate each new read request.
module disp_inflight_cnt #(
    parameter int C_BURST_LEN  = 16,
    parameter int C_FIFO_DEPTH = 512,
    parameter int C_CNT_WIDTH  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ar_hs,
    input  logic                   i_r_hs,
    input  logic [C_CNT_WIDTH-1:0] i_fifo_wcnt,
    output logic                   o_space_ok,
    output logic                   o_zero_nxt
);
    localparam int W = C_CNT_WIDTH + 2;
    logic [C_CNT_WIDTH-1:0] r_cnt, w_cnt;
    logic w_dec;
    // Saturate at zero: stray beats (e.g. after reset) never underflow.
    assign w_dec = i_r_hs && (r_cnt != '0 || i_ar_hs);
    assign w_cnt = r_cnt + (i_ar_hs ? C_CNT_WIDTH'(C_BURST_LEN) : '0) - C_CNT_WIDTH'(w_dec);
    assign o_zero_nxt = w_cnt == '0;
    // A handshake in this cycle is counted too, so back-to-back requests stay safe.
    assign o_space_ok = (W'(r_cnt) + W'(i_fifo_wcnt) + W'(C_BURST_LEN)
                         + (i_ar_hs ? W'(C_BURST_LEN) : W'(0))) <= W'(C_FIFO_DEPTH);
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= w_cnt;
endmodule

// File: rtl/disp_vramctrl.sv
// disp_vramctrl: per-frame AXI read-burst scheduler that fills the display
// FIFO from the framebuffer, one frame per VSTART.
module disp_vramctrl
    import disp_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 64,
    parameter int C_BURST_LEN      = 16,
    parameter int C_FIFO_DEPTH     = 512,
    parameter int C_CNT_WIDTH      = 10,
    parameter int C_BURSTS_VGA     = P_BURSTS_VGA,
    parameter int C_BURSTS_XGA     = P_BURSTS_XGA,
    parameter int C_BURSTS_SXGA    = P_BURSTS_SXGA
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   DISPON,
    input  logic [31:0]            DISPADDR,
    input  logic [1:0]             RESOL,
    input  logic                   VSTART,
    input  logic [C_CNT_WIDTH-1:0] FIFO_WCNT,
    output logic [31:0]            ARADDR,
    output logic [7:0]             ARLEN,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic                   RVALID,
    input  logic                   RLAST,
    output logic                   RREADY,
    output logic                   BUSY,
    output logic                   FRAME_DONE,
    output logic                   VS_MISS
);
    localparam int L_BURST_BYTES = C_BURST_LEN * C_AXI_DATA_WIDTH / 8;
    state_t r_state, w_state;
    logic [31:0] r_base, r_araddr, w_araddr;
    logic [1:0]  r_resol;
    logic [15:0] r_burst_cnt, w_burst_cnt, w_cnt_nxt, w_total;
    logic r_arvalid, w_arvalid, r_busy, r_frame_done, w_frame_done, r_vs_miss, r_rready;
    logic w_ar_hs, w_r_hs, w_space_ok, w_zero_nxt, w_start;

    assign w_ar_hs   = r_arvalid & ARREADY;
    assign w_r_hs    = RVALID & r_rready;
    assign w_cnt_nxt = r_burst_cnt + 16'(w_ar_hs);
    assign w_start   = (r_state == S_WAITVS) && DISPON && VSTART;
    assign w_total   = r_resol == P_RESOL_XGA  ? 16'(C_BURSTS_XGA)  :
                       r_resol == P_RESOL_SXGA ? 16'(C_BURSTS_SXGA) : 16'(C_BURSTS_VGA);

    disp_inflight_cnt #(
        .C_BURST_LEN (C_BURST_LEN),
        .C_FIFO_DEPTH(C_FIFO_DEPTH),
        .C_CNT_WIDTH (C_CNT_WIDTH)
    ) u_inflight (
        .i_clk      (ACLK),
        .i_rst      (ARESET),
        .i_ar_hs    (w_ar_hs),
        .i_r_hs     (w_r_hs),
        .i_fifo_wcnt(FIFO_WCNT),
        .o_space_ok (w_space_ok),
        .o_zero_nxt (w_zero_nxt)
    );

    always_comb begin
        w_state      = r_state;
        w_arvalid    = 1'b0;
        w_araddr     = r_araddr;
        w_frame_done = 1'b0;
        w_burst_cnt  = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                w_araddr = '0;
                w_state  = DISPON ? S_WAITVS : S_IDLE;
            end
            S_WAITVS: begin
                w_state     = !DISPON ? S_IDLE : VSTART ? S_ISSUE : S_WAITVS;
                w_burst_cnt = w_start ? '0 : r_burst_cnt;
            end
            S_ISSUE: begin
                w_burst_cnt = w_cnt_nxt;
                // A stalled request keeps its address; otherwise prepare the next one.
                if (r_arvalid && !ARREADY)
                    w_arvalid = 1'b1;
                else if (w_cnt_nxt == w_total)
                    w_state = S_DRAIN;
                else begin
                    w_arvalid = w_space_ok;
                    w_araddr  = r_base + 32'(w_cnt_nxt) * 32'(L_BURST_BYTES);
                end
            end
            S_DRAIN:
                if (w_r_hs && RLAST && w_zero_nxt) begin
                    w_frame_done = 1'b1;
                    w_state      = DISPON ? S_WAITVS : S_IDLE;
                end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_resol      <= '0;
            r_burst_cnt  <= '0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_vs_miss    <= 1'b0;
            r_rready     <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_burst_cnt  <= w_burst_cnt;
            r_arvalid    <= w_arvalid;
            r_araddr     <= w_araddr;
            r_busy       <= w_state == S_ISSUE || w_state == S_DRAIN;
            r_frame_done <= w_frame_done;
            r_vs_miss    <= VSTART && (r_state == S_ISSUE || r_state == S_DRAIN);
            r_rready     <= 1'b1;
            if (w_start) begin
                r_base  <= DISPADDR & 32'hFFFF_FF80;
                r_resol <= RESOL;
            end
        end

    assign ARADDR     = r_araddr;
    assign ARLEN      = 8'(C_BURST_LEN - 1);
    assign ARVALID    = r_arvalid;
    assign RREADY     = r_rready;
    assign BUSY       = r_busy;
    assign FRAME_DONE = r_frame_done;
    assign VS_MISS    = r_vs_miss;
endmodule
